// File: rtl/sgd_pkg.sv
// Shared definitions for the SGD server broadcast stage: bus defaults,
// metadata/status field layout, FSM state encoding and a saturating helper.
package sgd_pkg;

  // Default TX data bus width in bits.
  localparam int TX_BUS_WIDTH = 512;

  // Metadata and status words are both 64 bits wide.
  localparam int META_W = 64;

  // Metadata layout: [15:0] session, [31:16] payload length in bytes.
  localparam int META_SESSION_LSB = 0;
  localparam int META_SESSION_W   = 16;
  localparam int META_LEN_LSB     = 16;
  localparam int META_LEN_W       = 16;

  // Status layout: [15:0] session, [63:62] error code (0 = success).
  localparam int STATUS_SESSION_LSB = 0;
  localparam int STATUS_ERR_LSB     = 62;
  localparam int STATUS_ERR_W       = 2;

  // Broadcast engine states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_META,
    ST_DATA,
    ST_DONE
  } bcast_state_e;

  // 32-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/distram_fifo.sv
// Record FIFO on distributed RAM with a registered read port (latency 1).
// A write presented while full is ignored; fullness is judged before any
// read in the same cycle, so a simultaneous read never makes room for it.
module distram_fifo #(
  parameter int WIDTH      = 256,
  parameter int DEPTH_BITS = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic [WIDTH-1:0]      rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  do_wr, do_rd;

  assign full  = (count_q == (DEPTH_BITS + 1)'(DEPTH));
  assign empty = (count_q == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Next pointer, occupancy and read-port values.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = do_rd;
    if (do_wr) begin
      wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
    end
    if (do_rd) begin
      rd_ptr_d  = rd_ptr_q + DEPTH_BITS'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (DEPTH_BITS + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_BITS + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the RAM contents are deliberately not reset; the pointers define validity.
    if (do_wr) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Pointer, occupancy and read-port registers; reset flushes the FIFO.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample together.
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: rtl/sgd_server_bcast.sv
// Broadcast stage of the SGD server: captures one result record per strobe,
// queues it, then sends it as a multi-beat TCP payload to every worker session
// enabled at the time the record is dequeued, lowest worker index first.
module sgd_server_bcast
  import sgd_pkg::*;
#(
  parameter int WORKER_NUM      = 8,
  parameter int NUM_OF_BANKS    = 8,
  parameter int FIFO_DEPTH_BITS = 6,
  parameter int BUS_WIDTH       = TX_BUS_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [WORKER_NUM-1:0][15:0]         session_id,
  input  logic [WORKER_NUM-1:0]               worker_en,
  input  logic signed [NUM_OF_BANKS-1:0][31:0] result,
  input  logic [NUM_OF_BANKS-1:0]             result_valid,
  output logic                                s_axis_tx_metadata_valid,
  input  logic                                s_axis_tx_metadata_ready,
  output logic [META_W-1:0]                   s_axis_tx_metadata_data,
  output logic                                s_axis_tx_data_valid,
  input  logic                                s_axis_tx_data_ready,
  output logic [BUS_WIDTH-1:0]                s_axis_tx_data_data,
  output logic [BUS_WIDTH/8-1:0]              s_axis_tx_data_keep,
  output logic                                s_axis_tx_data_last,
  input  logic                                m_axis_tx_status_valid,
  output logic                                m_axis_tx_status_ready,
  input  logic [META_W-1:0]                   m_axis_tx_status_data,
  output logic [31:0]                         overflow_cnt,
  output logic [31:0]                         status_err_cnt,
  output logic [31:0]                         record_cnt,
  output logic                                busy
);

  localparam int REC_W     = 32 * NUM_OF_BANKS;
  localparam int BEATS     = (REC_W + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int PAD_W     = BEATS * BUS_WIDTH;
  localparam int BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WIDX_W    = (WORKER_NUM > 1) ? $clog2(WORKER_NUM) : 1;
  localparam int LEN_BYTES = PAD_W / 8;

  // Index of the lowest set bit; callers only use it on a nonzero mask.
  function automatic logic [WIDX_W-1:0] lowest_idx(input logic [WORKER_NUM-1:0] mask);
    logic [WIDX_W-1:0] idx;
    idx = '0;
    for (int i = WORKER_NUM - 1; i >= 0; i--) begin
      if (mask[i]) idx = WIDX_W'(i);
    end
    return idx;
  endfunction

  // Beat k of a zero-padded record.
  function automatic logic [BUS_WIDTH-1:0] beat_slice(input logic [PAD_W-1:0] pad,
                                                      input logic [BEAT_W-1:0] k);
    return pad[int'(k) * BUS_WIDTH +: BUS_WIDTH];
  endfunction

  // ---------------------------------------------------------------------------
  // Input capture and record FIFO
  // ---------------------------------------------------------------------------
  logic [REC_W-1:0] rec_in_q, rec_in_d;
  logic             res_valid_q, res_valid_d;
  logic [REC_W-1:0] fifo_rd_data;
  logic             fifo_rd_valid, fifo_full, fifo_empty;
  logic             rd_en_q, rd_en_d;

  // Only bank 0's strobe qualifies a record; the other strobes are ignored.
  assign rec_in_d    = result;
  assign res_valid_d = result_valid[0];

  distram_fifo #(
    .WIDTH      (REC_W),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (res_valid_q),
    .wr_data  (rec_in_q),
    .rd_en    (rd_en_q),
    .rd_data  (fifo_rd_data),
    .rd_valid (fifo_rd_valid),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Overflow and TX-status error accounting
  // ---------------------------------------------------------------------------
  logic [31:0] overflow_cnt_q, overflow_cnt_d;
  logic [31:0] status_err_cnt_q, status_err_cnt_d;
  logic        status_err;

  assign status_err = (m_axis_tx_status_data[STATUS_ERR_LSB +: STATUS_ERR_W] != '0);

  // Saturating counts of records dropped on a full FIFO and errored status beats.
  always_comb begin
    overflow_cnt_d   = overflow_cnt_q;
    status_err_cnt_d = status_err_cnt_q;
    if (res_valid_q && fifo_full) begin
      overflow_cnt_d = sat_inc(overflow_cnt_q);
    end
    if (m_axis_tx_status_valid && status_err) begin
      status_err_cnt_d = sat_inc(status_err_cnt_q);
    end
  end

  // Capture register and accounting counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rec_in_q         <= '0;
      res_valid_q      <= 1'b0;
      overflow_cnt_q   <= '0;
      status_err_cnt_q <= '0;
    end else begin
      rec_in_q         <= rec_in_d;
      res_valid_q      <= res_valid_d;
      overflow_cnt_q   <= overflow_cnt_d;
      status_err_cnt_q <= status_err_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Broadcast engine
  // ---------------------------------------------------------------------------
  bcast_state_e          state_q, state_d;
  logic [REC_W-1:0]      rec_q, rec_d;
  logic [PAD_W-1:0]      rec_pad;
  logic [WORKER_NUM-1:0] pending_q, pending_d;
  logic [WIDX_W-1:0]     cur_w;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  meta_valid_q, meta_valid_d;
  logic [15:0]           meta_session_q, meta_session_d;
  logic                  data_valid_q, data_valid_d;
  logic [BUS_WIDTH-1:0]  data_q, data_d;
  logic                  last_q, last_d;
  logic [31:0]           record_cnt_q, record_cnt_d;

  assign rec_pad = PAD_W'(rec_q);
  assign cur_w   = lowest_idx(pending_q);

  // Next-state and registered-output logic; session and payload are loaded
  // when valid rises so they stay frozen while the sink holds ready low.
  always_comb begin
    state_d        = state_q;
    rd_en_d        = 1'b0;
    rec_d          = rec_q;
    pending_d      = pending_q;
    beat_d         = beat_q;
    meta_valid_d   = meta_valid_q;
    meta_session_d = meta_session_q;
    data_valid_d   = data_valid_q;
    data_d         = data_q;
    last_d         = last_q;
    record_cnt_d   = record_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          rd_en_d = 1'b1;
          state_d = ST_READ;
        end
      end

      ST_READ: begin
        if (fifo_rd_valid) begin
          rec_d     = fifo_rd_data;
          pending_d = worker_en;
          if (worker_en == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d        = ST_META;
            meta_valid_d   = 1'b1;
            meta_session_d = session_id[lowest_idx(worker_en)];
          end
        end
      end

      ST_META: begin
        if (meta_valid_q && s_axis_tx_metadata_ready) begin
          pending_d[cur_w] = 1'b0;
          beat_d           = '0;
          meta_valid_d     = 1'b0;
          data_valid_d     = 1'b1;
          data_d           = beat_slice(rec_pad, '0);
          last_d           = (BEATS == 1);
          state_d          = ST_DATA;
        end
      end

      ST_DATA: begin
        if (data_valid_q && s_axis_tx_data_ready) begin
          if (last_q) begin
            data_valid_d = 1'b0;
            last_d       = 1'b0;
            if (pending_q != '0) begin
              state_d        = ST_META;
              meta_valid_d   = 1'b1;
              meta_session_d = session_id[cur_w];
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
            data_d = beat_slice(rec_pad, beat_d);
            last_d = (beat_d == BEAT_W'(BEATS - 1));
          end
        end
      end

      ST_DONE: begin
        record_cnt_d = sat_inc(record_cnt_q);
        state_d      = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Engine state and registered outputs; reset aborts any packet in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      rd_en_q        <= 1'b0;
      rec_q          <= '0;
      pending_q      <= '0;
      beat_q         <= '0;
      meta_valid_q   <= 1'b0;
      meta_session_q <= '0;
      data_valid_q   <= 1'b0;
      data_q         <= '0;
      last_q         <= 1'b0;
      record_cnt_q   <= '0;
    end else begin
      state_q        <= state_d;
      rd_en_q        <= rd_en_d;
      rec_q          <= rec_d;
      pending_q      <= pending_d;
      beat_q         <= beat_d;
      meta_valid_q   <= meta_valid_d;
      meta_session_q <= meta_session_d;
      data_valid_q   <= data_valid_d;
      data_q         <= data_d;
      last_q         <= last_d;
      record_cnt_q   <= record_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Metadata word assembled from the latched session and the fixed length.
  always_comb begin
    s_axis_tx_metadata_data = '0;
    s_axis_tx_metadata_data[META_SESSION_LSB +: META_SESSION_W] = meta_session_q;
    s_axis_tx_metadata_data[META_LEN_LSB +: META_LEN_W]         = META_LEN_W'(LEN_BYTES);
  end

  assign s_axis_tx_metadata_valid = meta_valid_q;
  assign s_axis_tx_data_valid     = data_valid_q;
  assign s_axis_tx_data_data      = data_q;
  assign s_axis_tx_data_keep      = '1;
  assign s_axis_tx_data_last      = last_q;
  assign m_axis_tx_status_ready   = 1'b1;
  assign overflow_cnt             = overflow_cnt_q;
  assign status_err_cnt           = status_err_cnt_q;
  assign record_cnt               = record_cnt_q;
  assign busy                     = (state_q != ST_IDLE) || !fifo_empty;

  // Status session bits and the non-qualifying strobes carry no function here.
  logic unused_inputs;
  assign unused_inputs = ^{m_axis_tx_status_data, result_valid};

endmodule

// File: tb/tb_sgd_server_bcast.sv
// Directed bench for sgd_server_bcast: a single-beat instance (8 banks) and a
// two-beat instance (32 banks) share workers, sessions and sink readiness.
module tb_sgd_server_bcast;

  localparam int WN = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [WN-1:0][15:0] session_id;
  logic [WN-1:0]       worker_en;
  logic                m_rdy, d_rdy;

  // 8-bank instance signals
  logic signed [7:0][31:0] result8;
  logic [7:0]              rv8;
  logic                    mv8, dv8, dl8, sr8, busy8, st_v8;
  logic [63:0]             md8, st_d8;
  logic [511:0]            dd8;
  logic [63:0]             dk8;
  logic [31:0]             ovf8, serr8, rcnt8;

  // 32-bank instance signals
  logic signed [31:0][31:0] result32;
  logic [31:0]              rv32;
  logic                     mv32, dv32, dl32, sr32, busy32, st_v32;
  logic [63:0]              md32, st_d32;
  logic [511:0]             dd32;
  logic [63:0]              dk32;
  logic [31:0]              ovf32, serr32, rcnt32;

  sgd_server_bcast #(.WORKER_NUM(WN), .NUM_OF_BANKS(8), .FIFO_DEPTH_BITS(6), .BUS_WIDTH(512)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .session_id(session_id), .worker_en(worker_en),
    .result(result8), .result_valid(rv8),
    .s_axis_tx_metadata_valid(mv8), .s_axis_tx_metadata_ready(m_rdy), .s_axis_tx_metadata_data(md8),
    .s_axis_tx_data_valid(dv8), .s_axis_tx_data_ready(d_rdy), .s_axis_tx_data_data(dd8),
    .s_axis_tx_data_keep(dk8), .s_axis_tx_data_last(dl8),
    .m_axis_tx_status_valid(st_v8), .m_axis_tx_status_ready(sr8), .m_axis_tx_status_data(st_d8),
    .overflow_cnt(ovf8), .status_err_cnt(serr8), .record_cnt(rcnt8), .busy(busy8)
  );

  sgd_server_bcast #(.WORKER_NUM(WN), .NUM_OF_BANKS(32), .FIFO_DEPTH_BITS(2), .BUS_WIDTH(512)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .session_id(session_id), .worker_en(worker_en),
    .result(result32), .result_valid(rv32),
    .s_axis_tx_metadata_valid(mv32), .s_axis_tx_metadata_ready(m_rdy), .s_axis_tx_metadata_data(md32),
    .s_axis_tx_data_valid(dv32), .s_axis_tx_data_ready(d_rdy), .s_axis_tx_data_data(dd32),
    .s_axis_tx_data_keep(dk32), .s_axis_tx_data_last(dl32),
    .m_axis_tx_status_valid(st_v32), .m_axis_tx_status_ready(sr32), .m_axis_tx_status_data(st_d32),
    .overflow_cnt(ovf32), .status_err_cnt(serr32), .record_cnt(rcnt32), .busy(busy32)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Handshake logs and protocol-violation tallies collected by the monitors.
  logic [63:0]  meta8_q[$], meta32_q[$];
  logic [512:0] data8_q[$], data32_q[$];
  int overlap8 = 0, overlap32 = 0;
  int stab_m8 = 0, stab_d8 = 0, stab_m32 = 0, stab_d32 = 0;
  int keep_bad8 = 0, keep_bad32 = 0;

  logic         pmv8 = 1'b0, pmr8 = 1'b0, pdv8 = 1'b0, pdr8 = 1'b0;
  logic [63:0]  pmd8 = '0;
  logic [512:0] pdd8 = '0;
  logic         pmv32 = 1'b0, pmr32 = 1'b0, pdv32 = 1'b0, pdr32 = 1'b0;
  logic [63:0]  pmd32 = '0;
  logic [512:0] pdd32 = '0;

  // 8-bank monitor: logs handshakes mid-cycle and flags stall instability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mv8 && dv8) overlap8 <= overlap8 + 1;
      if (pmv8 && !pmr8 && (!mv8 || md8 !== pmd8)) stab_m8 <= stab_m8 + 1;
      if (pdv8 && !pdr8 && (!dv8 || {dl8, dd8} !== pdd8)) stab_d8 <= stab_d8 + 1;
      if (mv8 && m_rdy) meta8_q.push_back(md8);
      if (dv8 && d_rdy) begin
        data8_q.push_back({dl8, dd8});
        if (dk8 !== '1) keep_bad8 <= keep_bad8 + 1;
      end
    end
    pmv8 <= rst_n && mv8;
    pmr8 <= m_rdy;
    pmd8 <= md8;
    pdv8 <= rst_n && dv8;
    pdr8 <= d_rdy;
    pdd8 <= {dl8, dd8};
  end

  // 32-bank monitor, same checks.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mv32 && dv32) overlap32 <= overlap32 + 1;
      if (pmv32 && !pmr32 && (!mv32 || md32 !== pmd32)) stab_m32 <= stab_m32 + 1;
      if (pdv32 && !pdr32 && (!dv32 || {dl32, dd32} !== pdd32)) stab_d32 <= stab_d32 + 1;
      if (mv32 && m_rdy) meta32_q.push_back(md32);
      if (dv32 && d_rdy) begin
        data32_q.push_back({dl32, dd32});
        if (dk32 !== '1) keep_bad32 <= keep_bad32 + 1;
      end
    end
    pmv32 <= rst_n && mv32;
    pmr32 <= m_rdy;
    pmd32 <= md32;
    pdv32 <= rst_n && dv32;
    pdr32 <= d_rdy;
    pdd32 <= {dl32, dd32};
  end

  task automatic check(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push8(input logic [255:0] rec, input logic [7:0] strobe);
    result8 = rec;
    rv8     = strobe;
    tick();
    rv8     = 8'h00;
  endtask

  task automatic push32(input logic [1023:0] rec);
    result32 = rec;
    rv32     = 32'h1;
    tick();
    rv32     = 32'h0;
  endtask

  task automatic wait_rcnt(input bit sel32, input int target, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if ((sel32 ? rcnt32 : rcnt8) == 32'(target)) break;
      tick();
    end
    check(tag, sel32 ? rcnt32 : rcnt8, 32'(target));
  endtask

  // Record k: bank n holds k*256+n, negated for odd k (record 0 is 0..7).
  function automatic logic [255:0] mk_rec8(input int k);
    logic [255:0] r;
    logic [31:0]  v;
    for (int n = 0; n < 8; n++) begin
      v = 32'(k * 256 + n);
      r[n*32 +: 32] = (k % 2 == 1) ? -v : v;
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_meta(input int w, input int len);
    return {32'd0, 16'(len), 16'h0100 + 16'(w)};
  endfunction

  logic [1023:0] rec32;
  logic [255:0]  rec8;

  initial begin
    rst_n     = 1'b0;
    worker_en = '0;
    m_rdy     = 1'b0;
    d_rdy     = 1'b0;
    result8   = '0;
    rv8       = '0;
    result32  = '0;
    rv32      = '0;
    st_v8     = 1'b0;
    st_d8     = '0;
    st_v32    = 1'b0;
    st_d32    = '0;
    for (int w = 0; w < WN; w++) session_id[w] = 16'h0100 + 16'(w);

    // Reset state
    tick(3);
    check("rst_meta_valid", mv8, 1'b0);
    check("rst_data_valid", dv8, 1'b0);
    check("rst_last", dl8, 1'b0);
    check("rst_busy", busy8, 1'b0);
    check("rst_counters", {ovf8, serr8, rcnt8}, 96'd0);
    check("rst_status_ready", sr8, 1'b1);
    check("rst32_idle", {mv32, dv32, busy32, rcnt32}, 35'd0);
    rst_n = 1'b1;
    tick();

    // Full mask, single-beat record 0..7 to all eight sessions
    worker_en = 8'hFF;
    m_rdy     = 1'b1;
    d_rdy     = 1'b1;
    rec8      = mk_rec8(0);
    push8(rec8, 8'h01);
    wait_rcnt(1'b0, 1, 200, "t1_record_cnt");
    check("t1_meta_count", meta8_q.size(), 8);
    check("t1_data_count", data8_q.size(), 8);
    for (int w = 0; w < 8; w++) begin
      check($sformatf("t1_meta_w%0d", w), meta8_q[w], exp_meta(w, 64));
      check($sformatf("t1_data_w%0d", w), data8_q[w], {1'b1, 256'd0, rec8});
    end
    check("t1_busy_after", busy8, 1'b0);
    meta8_q.delete();
    data8_q.delete();

    // Two-beat records to workers 0 and 2 only
    worker_en = 8'b0000_0101;
    for (int n = 0; n < 32; n++) rec32[n*32 +: 32] = 32'hA000_0000 + 32'(n * 3);
    push32(rec32);
    wait_rcnt(1'b1, 1, 200, "t2_record_cnt");
    check("t2_meta_count", meta32_q.size(), 2);
    check("t2_meta_w0", meta32_q[0], exp_meta(0, 128));
    check("t2_meta_w2", meta32_q[1], exp_meta(2, 128));
    check("t2_data_count", data32_q.size(), 4);
    check("t2_w0_beat0", data32_q[0], {1'b0, rec32[511:0]});
    check("t2_w0_beat1", data32_q[1], {1'b1, rec32[1023:512]});
    check("t2_w2_beat0", data32_q[2], {1'b0, rec32[511:0]});
    check("t2_w2_beat1", data32_q[3], {1'b1, rec32[1023:512]});

    // Strobes other than bit 0 do not create a record
    worker_en = 8'hFF;
    push8(mk_rec8(9), 8'hFE);
    tick(10);
    check("t3_no_record_cnt", rcnt8, 32'd1);
    check("t3_no_record_tx", meta8_q.size(), 0);

    // Empty mask: record is discarded without TX traffic
    worker_en = 8'h00;
    push8(mk_rec8(1), 8'h01);
    wait_rcnt(1'b0, 2, 100, "t3_discard_cnt");
    check("t3_discard_meta", meta8_q.size(), 0);
    check("t3_discard_data", data8_q.size(), 0);
    check("t3_discard_busy", busy8, 1'b0);

    // Overflow: the engine holds one record stalled in META, so the 70 that
    // follow fill the 64-entry FIFO and 6 are dropped
    worker_en = 8'h01;
    m_rdy     = 1'b0;
    d_rdy     = 1'b0;
    push8(mk_rec8(2), 8'h01);
    for (int i = 0; i < 20 && !mv8; i++) tick();
    check("t4_engine_holds", mv8, 1'b1);
    for (int i = 0; i < 70; i++) push8(mk_rec8(100 + i), 8'h01);
    tick(30);
    check("t4_overflow_cnt", ovf8, 32'd6);
    check("t4_busy_stalled", busy8, 1'b1);
    m_rdy = 1'b1;
    d_rdy = 1'b1;
    wait_rcnt(1'b0, 67, 3000, "t4_record_cnt");
    check("t4_meta_count", meta8_q.size(), 65);
    check("t4_data_count", data8_q.size(), 65);
    check("t4_meta_first", meta8_q[0], exp_meta(0, 64));
    check("t4_meta_last", meta8_q[64], exp_meta(0, 64));
    for (int j = 0; j < 65; j++) begin
      check($sformatf("t4_data_%0d", j), data8_q[j],
            {1'b1, 256'd0, mk_rec8((j == 0) ? 2 : 100 + j - 1)});
    end
    meta8_q.delete();
    data8_q.delete();

    // Status: three errored beats, two clean, one errored word without valid
    for (int i = 0; i < 5; i++) begin
      st_v8 = 1'b1;
      st_d8 = (i < 3) ? {2'b01, 46'd0, 16'h0100 + 16'(i)} : {2'b00, 46'h3FF, 16'h0105};
      tick();
    end
    st_v8 = 1'b0;
    st_d8 = {2'b11, 62'd0};
    tick(2);
    check("t5_status_err_cnt", serr8, 32'd3);
    check("t5_tx_untouched", meta8_q.size() + data8_q.size(), 0);

    // Reset in the middle of a data beat aborts the packet at once
    worker_en = 8'hFF;
    m_rdy     = 1'b1;
    d_rdy     = 1'b0;
    push8(mk_rec8(7), 8'h01);
    for (int i = 0; i < 30 && !dv8; i++) tick();
    check("t6_in_data", dv8, 1'b1);
    rst_n = 1'b0;
    tick();
    check("t6_valids", {mv8, dv8, dl8}, 3'b000);
    check("t6_counters", {ovf8, serr8, rcnt8}, 96'd0);
    check("t6_busy", busy8, 1'b0);
    rst_n = 1'b1;
    d_rdy = 1'b1;
    tick(20);
    check("t6_meta_before_rst", meta8_q.size(), 1);
    check("t6_no_beats_after", data8_q.size(), 0);
    check("t6_idle_after", {mv8, dv8, busy8}, 3'b000);

    // Protocol invariants gathered over the whole run
    check("no_meta_data_overlap", overlap8 + overlap32, 0);
    check("stall_stable", stab_m8 + stab_d8 + stab_m32 + stab_d32, 0);
    check("keep_all_ones", keep_bad8 + keep_bad32, 0);
    check("dut32_quiet_counters", {ovf32, serr32, sr32}, 65'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sgd_server_bcast.md
# sgd_server_bcast

Parametrised broadcast stage of the SGD server. Captures one per-bank result record (NUM_OF_BANKS × 32-bit signed values) per valid strobe, buffers it in a FIFO and sends it as a multi-beat TCP payload to every enabled worker session, one session at a time. Sits between the gradient/dot-product pipeline and the TCP TX engine. Adds a runtime worker mask, multi-beat records, overflow accounting and TX-status error counting.

## Interface
Parameters:
- WORKER_NUM, 8, number of worker sessions (1..16)
- NUM_OF_BANKS, 8, 32-bit results per record (1..64)
- FIFO_DEPTH_BITS, 6, log2 record FIFO depth
- BUS_WIDTH, 512, TX data bus width in bits

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- session_id  in  [WORKER_NUM-1:0][15:0]  session per worker
- worker_en  in  WORKER_NUM  broadcast mask, sampled per record
- result  in  [NUM_OF_BANKS-1:0] signed [31:0]  bank results
- result_valid  in  [NUM_OF_BANKS-1:0]  only bit 0 qualifies a record
- s_axis_tx_metadata  axis_meta.master  [15:0] session, [31:16] length bytes, rest 0
- s_axis_tx_data  axi_stream.master  payload beats, keep all-ones
- m_axis_tx_status  axis_meta.slave  [15:0] session, [63:62] error code
- overflow_cnt  out  32  records dropped on full FIFO
- status_err_cnt  out  32  status beats with nonzero error
- record_cnt  out  32  records fully broadcast or discarded
- busy  out  1  state ≠ IDLE or FIFO non-empty

## Operation
- BEATS = ceil(32·NUM_OF_BANKS / BUS_WIDTH); length = BEATS·BUS_WIDTH/8. Bank n sits at record bits [32n+31:32n]; beat k carries record bits [k·BUS_WIDTH +: BUS_WIDTH], zero-padded above the record.
- Input registered one cycle; FIFO write on the registered result_valid[0]. If the FIFO is full at write, the record is dropped and overflow_cnt increments (saturating).
- States: IDLE, READ, META, DATA, DONE.
- IDLE: FIFO non-empty → pulse rd_en one cycle, go READ.
- READ: on FIFO valid, latch record and pending = worker_en. pending == 0 → DONE (discard). Otherwise → META.
- META: worker w = lowest set bit of pending; metadata.valid = 1 with session_id[w]. On valid&ready → clear bit w, beat = 0, go DATA.
- DATA: data.valid = 1; last = (beat == BEATS-1). Each handshake advances beat. On last handshake: pending ≠ 0 → META, else DONE.
- DONE: record_cnt++, → IDLE.
- Status: ready tied 1; each valid beat with [63:62] ≠ 0 increments status_err_cnt (saturating). Status never stalls or alters sends.
- worker_en and session_id changes mid-record do not affect the pending mask; session_id is read in META.

## Timing
- Reset: all outputs, counters, valids, last and busy = 0; FIFO flushed; state IDLE. Reset mid-packet aborts immediately; no further beats.
- Result capture → FIFO non-empty: 2 cycles. IDLE → first metadata.valid: ≥3 cycles (rd_en, read latency 1, latch).
- Valid/data/session stable while valid & !ready (AXI-Stream rules). Metadata and data are never valid in the same cycle.
- Back-to-back records: one IDLE cycle between DONE and next READ.
- Simultaneous FIFO write and read while full: write still dropped (full sampled before read).

## Structure
- Shared package sgd_pkg: BUS_WIDTH, meta field offsets, status error field, state enum.
- Sub-module: distram_fifo (width 32·NUM_OF_BANKS, depth 2^FIFO_DEPTH_BITS, read latency 1).

## Test plan
- NUM_OF_BANKS=8, mask 8'hFF, one record 0..7 → 8 metadata (sessions 0..7, length 64), 8 single-beat packets with bits [255:0] = record, upper 0; record_cnt=1.
- NUM_OF_BANKS=32, mask 8'b0000_0101 → 2 packets (workers 0, 2), 2 beats each, last on beat 1, length 128.
- Mask 0 → no TX traffic, record_cnt increments, FIFO drains.
- Hold metadata/data ready low 100 cycles, inject 70 records (depth 64) → overflow_cnt=6, all 64 buffered records later sent intact.
- Status beats with [63:62]=2'b01 ×3, 2'b00 ×2 → status_err_cnt=3.
- Assert rst_n low mid-DATA → next cycle valids 0, counters 0, busy 0.
